// File: rtl/rriscv_pkg.sv
// rriscv_pkg: shared op/err/state enums, instruction encoding constants and immediate range limits
package rriscv_pkg;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {OP_ADD, OP_MUL, OP_ADDI, OP_LW, OP_SW, OP_JAL, OP_BNE} op_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_OP, ERR_IMM, ERR_OVF} err_code_e;
  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_FLUSH, S_DONE, S_ERROR} state_e;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_MUL = 7'b0000001;
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMMB_MIN  = -4096;
  localparam int IMMB_MAX  = 4094;
  localparam int IMMJ_MIN  = -(1 << 20);
  localparam int IMMJ_MAX  = (1 << 20) - 2;
  function automatic logic in_range(input logic [XLEN-1:0] v, input int lo, input int hi, input logic even);
    return $signed(v) >= lo && $signed(v) <= hi && !(even && v[0]);
  endfunction
endpackage

// File: rtl/program_encoder_imm_packer.sv
// imm_packer: places the immediate into its I/S/B/J bit positions (op, imm -> placed, range_ok)
module imm_packer
  import rriscv_pkg::*;
(
  input  op_e             op,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] placed,
  output logic            range_ok
);
  logic [XLEN-1:0] i_f, s_f, b_f, j_f;
  assign i_f = {imm[11:0], 20'd0};
  assign s_f = {imm[11:5], 13'd0, imm[4:0], 7'd0};
  assign b_f = {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
  assign j_f = {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
  assign placed = (op == OP_ADDI || op == OP_LW) ? i_f :
                  op == OP_SW  ? s_f :
                  op == OP_BNE ? b_f :
                  op == OP_JAL ? j_f : '0;
  assign range_ok = op inside {OP_ADDI, OP_LW, OP_SW} ? in_range(imm, IMM12_MIN, IMM12_MAX, 1'b0) :
                    op == OP_BNE ? in_range(imm, IMMB_MIN, IMMB_MAX, 1'b1) :
                    op == OP_JAL ? in_range(imm, IMMJ_MIN, IMMJ_MAX, 1'b1) : 1'b1;
endmodule

// File: rtl/program_encoder.sv
// program_encoder: encodes symbolic instructions from a valid/ready stream into 32-bit words written to consecutive memory addresses, with done/error status and word count
module program_encoder
  import rriscv_pkg::*;
#(
  parameter int              DEPTH     = 256,
  parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [2:0]             req_op_i,
  input  logic [4:0]             req_rd_i,
  input  logic [4:0]             req_rs1_i,
  input  logic [4:0]             req_rs2_i,
  input  logic [XLEN-1:0]        req_imm_i,
  input  logic                   req_last_i,
  output logic                   mem_we_o,
  output logic [XLEN-1:0]        mem_addr_o,
  output logic [XLEN-1:0]        mem_wdata_o,
  input  logic                   mem_ready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [1:0]             err_code_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_e state, state_nx;
  op_e op;
  err_code_e chk_code;
  logic [CW-1:0] acc_cnt;
  logic [XLEN-1:0] placed, word;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd_m, rs1_m, rs2_m;
  logic range_ok, hs, restart;
  assign op = op_e'(req_op_i);
  imm_packer u_imm_packer (.op(op), .imm(req_imm_i), .placed(placed), .range_ok(range_ok));
  assign opc = (op == OP_ADD || op == OP_MUL) ? OPC_OP :
               op == OP_ADDI ? OPC_OPIMM :
               op == OP_LW   ? OPC_LOAD :
               op == OP_SW   ? OPC_STORE :
               op == OP_JAL  ? OPC_JAL : OPC_BRANCH;
  assign f3 = (op == OP_LW || op == OP_SW) ? F3_W : op == OP_BNE ? F3_BNE : F3_ADD;
  assign f7 = op == OP_MUL ? F7_MUL : F7_ADD;
  assign rd_m  = op inside {OP_ADD, OP_MUL, OP_ADDI, OP_LW, OP_JAL} ? req_rd_i : 5'd0;
  assign rs1_m = op != OP_JAL ? req_rs1_i : 5'd0;
  assign rs2_m = op inside {OP_ADD, OP_MUL, OP_SW, OP_BNE} ? req_rs2_i : 5'd0;
  assign word = placed | {f7, rs2_m, rs1_m, f3, rd_m, opc};
  // the overflow limit counts accepted words, which may run one ahead of completed writes
  assign chk_code = req_op_i > OP_BNE ? ERR_OP :
                    !range_ok ? ERR_IMM :
                    acc_cnt == CW'(DEPTH) ? ERR_OVF : ERR_NONE;
  assign req_ready_o = state == S_ACCEPT && (!mem_we_o || mem_ready_i);
  assign hs = req_valid_i && req_ready_o;
  assign restart = start_i && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign busy_o = state == S_ACCEPT || state == S_FLUSH;
  assign done_o = state == S_DONE;
  assign mem_addr_o = BASE_ADDR + (XLEN'(count_o) << 2);
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: state_nx = start_i ? S_ACCEPT : state;
      S_ACCEPT: state_nx = !hs ? state : chk_code != ERR_NONE ? S_ERROR : req_last_i ? S_FLUSH : state;
      S_FLUSH:  state_nx = (!mem_we_o || mem_ready_i) ? S_DONE : state;
      default:  state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state       <= S_IDLE;
      mem_we_o    <= 1'b0;
      mem_wdata_o <= '0;
      count_o     <= '0;
      acc_cnt     <= '0;
      err_o       <= 1'b0;
      err_code_o  <= ERR_NONE;
    end else begin
      state <= state_nx;
      if (hs && chk_code == ERR_NONE) begin
        mem_we_o    <= 1'b1;
        mem_wdata_o <= word;
      end else if (mem_ready_i) mem_we_o <= 1'b0;
      if (restart) count_o <= '0;
      else if (mem_we_o && mem_ready_i) count_o <= count_o + CW'(1);
      if (restart) acc_cnt <= '0;
      else if (hs && chk_code == ERR_NONE) acc_cnt <= acc_cnt + CW'(1);
      if (restart) begin
        err_o      <= 1'b0;
        err_code_o <= ERR_NONE;
      end else if (hs && chk_code != ERR_NONE) begin
        err_o      <= 1'b1;
        err_code_o <= chk_code;
      end
    end
endmodule

// File: tb/tb_program_encoder.sv
// tb_program_encoder: randomized and directed checks of program_encoder against a behavioural scoreboard model
module tb_program_encoder;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h0;
  logic clk = 0, rst_n = 0, start = 0, req_valid = 0, req_last = 0, mem_ready = 1;
  logic [2:0] req_op = 0;
  logic [4:0] req_rd = 0, req_rs1 = 0, req_rs2 = 0;
  logic [31:0] req_imm = 0;
  logic req_ready, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0] err_code;
  logic [2:0] count;
  program_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_rd_i(req_rd), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_imm_i(req_imm),
    .req_last_i(req_last), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ready_i(mem_ready), .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(err_code), .count_o(count)
  );
  always #5 clk = ~clk;
  int n_tests = 0, n_fail = 0;
  logic m_acc = 0, m_flush = 0, m_done = 0, m_err = 0, hs_seen = 0, rand_ready = 0;
  logic [1:0] m_code = 0;
  int m_nacc = 0, m_nwr = 0;
  logic [63:0] exp_q[$];
  logic [31:0] wr_log[$];
  int edges[14] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098, 1048574, 1048576, -1048576, -1048578, 3};
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic void model_enc(input logic [2:0] op, input logic [4:0] d, s1, s2, input logic [31:0] u,
                                    output logic [31:0] w, output logic [1:0] code);
    int v;
    v = $signed(u);
    w = 0;
    code = 0;
    case (op)
      3'd0: w = {7'b0000000, s2, s1, 3'b000, d, 7'b0110011};
      3'd1: w = {7'b0000001, s2, s1, 3'b000, d, 7'b0110011};
      3'd2: begin
        if (v < -2048 || v > 2047) code = 2;
        w = {u[11:0], s1, 3'b000, d, 7'b0010011};
      end
      3'd3: begin
        if (v < -2048 || v > 2047) code = 2;
        w = {u[11:0], s1, 3'b010, d, 7'b0000011};
      end
      3'd4: begin
        if (v < -2048 || v > 2047) code = 2;
        w = {u[11:5], s2, s1, 3'b010, u[4:0], 7'b0100011};
      end
      3'd5: begin
        if (v < -(1 << 20) || v > (1 << 20) - 2 || v % 2 != 0) code = 2;
        w = {u[20], u[10:1], u[11], u[19:12], d, 7'b1101111};
      end
      3'd6: begin
        if (v < -4096 || v > 4094 || v % 2 != 0) code = 2;
        w = {u[12], u[10:5], s2, s1, 3'b001, u[4:1], u[11], 7'b1100011};
      end
      default: code = 1;
    endcase
    if (code == 0 && m_nacc == DEPTH) code = 3;
  endfunction
  task automatic step();
    logic pend, rdy, was_busy, hs;
    logic [31:0] w;
    logic [1:0] code;
    if (rand_ready) mem_ready = $urandom_range(0, 3) != 0;
    @(negedge clk);
    pend = exp_q.size() > 0;
    was_busy = m_acc || m_flush;
    rdy = m_acc && (!pend || mem_ready);
    check("we", mem_we, pend);
    check("ready", req_ready, rdy);
    check("busy", busy, was_busy);
    check("done", done, m_done);
    check("err", err, m_err);
    check("err_code", err_code, m_code);
    check("count", count, m_nwr);
    if (pend) begin
      check("addr", mem_addr, exp_q[0][63:32]);
      check("wdata", mem_wdata, exp_q[0][31:0]);
      if (mem_ready) begin
        wr_log.push_back(mem_wdata);
        void'(exp_q.pop_front());
        m_nwr++;
      end
    end
    if (m_flush && (!pend || mem_ready)) begin
      m_flush = 0;
      m_done = 1;
    end
    if (start && !was_busy) begin
      m_acc = 1; m_done = 0; m_err = 0; m_code = 0; m_nacc = 0; m_nwr = 0;
    end
    hs = req_valid && rdy;
    hs_seen = hs;
    if (hs) begin
      model_enc(req_op, req_rd, req_rs1, req_rs2, req_imm, w, code);
      if (code != 0) begin
        m_err = 1; m_code = code; m_acc = 0;
      end else begin
        exp_q.push_back({BASE + 32'(4 * m_nacc), w});
        m_nacc++;
        if (req_last) begin
          m_acc = 0; m_flush = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [2:0] op, input logic [4:0] d, s1, s2, input logic [31:0] iv, input logic last);
    req_op = op; req_rd = d; req_rs1 = s1; req_rs2 = s2; req_imm = iv; req_last = last; req_valid = 1;
    hs_seen = 0;
    for (int i = 0; i < 20 && !hs_seen; i++) step();
    check("handshake_timeout", hs_seen, 1);
    req_valid = 0;
    req_last = 0;
  endtask
  task automatic do_start();
    wr_log.delete();
    start = 1;
    step();
    start = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && (m_flush || exp_q.size() > 0); i++) step();
    check("drain_timeout", exp_q.size(), 0);
    step();
  endtask
  task automatic reset_checks(input string tag);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_code"}, err_code, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_addr"}, mem_addr, BASE);
  endtask
  initial begin
    #3;
    reset_checks("por");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    do_start();
    send(3'd2, 5'd1, 5'd0, 5'd0, 32'd5, 1);
    drain();
    check("addi_word", wr_log[0], 32'h00500093);
    check("addi_done", done, 1);
    do_start();
    send(3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0);
    send(3'd1, 5'd3, 5'd1, 5'd2, 32'd0, 0);
    send(3'd4, 5'd0, 5'd1, 5'd2, 32'd8, 1);
    drain();
    check("add_word", wr_log[0], 32'h002081B3);
    check("mul_word", wr_log[1], 32'h022081B3);
    check("sw_word", wr_log[2], 32'h0020A423);
    check("stream_count", count, 3);
    do_start();
    send(3'd6, 5'd0, 5'd1, 5'd2, -32'sd4, 0);
    mem_ready = 0;
    req_op = 3'd5; req_rd = 5'd1; req_rs1 = 0; req_rs2 = 0; req_imm = 32'd8; req_last = 1; req_valid = 1;
    repeat (3) step();
    mem_ready = 1;
    send(3'd5, 5'd1, 5'd0, 5'd0, 32'd8, 1);
    drain();
    check("bne_word", wr_log[0], 32'hFE209EE3);
    check("jal_word", wr_log[1], 32'h008000EF);
    do_start();
    send(3'd2, 5'd1, 5'd0, 5'd0, 32'd2048, 1);
    step();
    check("addi_range_code", err_code, 2);
    check("addi_range_writes", wr_log.size(), 0);
    do_start();
    send(3'd6, 5'd0, 5'd1, 5'd2, 32'd3, 1);
    step();
    check("bne_odd_code", err_code, 2);
    do_start();
    send(3'd7, 5'd1, 5'd1, 5'd1, 32'd0, 1);
    step();
    check("bad_op_code", err_code, 1);
    do_start();
    for (int k = 0; k < 5; k++) send(3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 0);
    drain();
    check("ovf_code", err_code, 3);
    check("ovf_writes", wr_log.size(), 4);
    do_start();
    send(3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 0);
    start = 1;
    step();
    start = 0;
    send(3'd1, 5'd4, 5'd5, 5'd6, 32'd0, 1);
    drain();
    check("start_ignored_count", count, 2);
    do_start();
    mem_ready = 0;
    send(3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 0);
    step();
    #2;
    rst_n = 0;
    #1;
    reset_checks("midrst");
    m_acc = 0; m_flush = 0; m_done = 0; m_err = 0; m_code = 0; m_nacc = 0; m_nwr = 0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    mem_ready = 1;
    do_start();
    send(3'd2, 5'd2, 5'd0, 5'd0, 32'd7, 1);
    drain();
    check("restart_count", count, 1);
    check("restart_word", wr_log[0], 32'h00700113);
    rand_ready = 1;
    repeat (60) begin
      int n;
      do_start();
      n = $urandom_range(1, 6);
      for (int k = 0; k < n && m_acc; k++) begin
        logic [2:0] op;
        logic [31:0] iv;
        op = $urandom_range(0, 15) == 0 ? 3'd7 : 3'($urandom_range(0, 6));
        case ($urandom_range(0, 3))
          0: iv = 32'($urandom_range(0, 40)) - 32'd20;
          1: iv = edges[$urandom_range(0, 13)];
          2: iv = 32'($urandom_range(0, 8191)) - 32'd4096;
          default: iv = 32'($urandom_range(0, 1 << 21)) - 32'(1 << 20);
        endcase
        send(op, 5'($urandom), 5'($urandom), 5'($urandom), iv, k == n - 1);
      end
      drain();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/program_encoder.md
# program_encoder

Sequential instruction encoder for the rriscv core: accepts symbolic instructions (operation, register indices, signed immediate) over a valid/ready stream. It packs each into the 32-bit R/I/S/B/J word format that the core's decode stage consumes, and writes the words into instruction memory at consecutive word addresses. It is the producer end of the instruction-word interface, used by the bench/boot path to load programs, and it flags unsupported operations, unencodable immediates and memory overflow.

## Interface
- XLEN, 32 (from rriscv_pkg), instruction and address width
- DEPTH, 256, instruction-memory capacity in words
- BASE_ADDR, 0, byte address of the first word written; must be 4-aligned
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  begin a new program; clears count and error state
- req_valid_i  in  1  instruction request valid
- req_ready_o  out  1  request accepted when valid and ready are both high
- req_op_i  in  3  op_e: OP_ADD, OP_MUL, OP_ADDI, OP_LW, OP_SW, OP_JAL, OP_BNE
- req_rd_i / req_rs1_i / req_rs2_i  in  5 each  register indices; unused fields ignored
- req_imm_i  in  XLEN  signed immediate in bytes
- req_last_i  in  1  marks the final instruction of the program
- mem_we_o  out  1  write request
- mem_addr_o  out  XLEN  byte address
- mem_wdata_o  out  XLEN  encoded instruction
- mem_ready_i  in  1  memory accepts the write this cycle
- busy_o, done_o, err_o  out  1 each  status
- err_code_o  out  2  0 none, 1 bad op, 2 bad immediate, 3 overflow
- count_o  out  $clog2(DEPTH)+1  words written

## Operation
- FSM states:
  - IDLE: start_i goes to ACCEPT.
  - ACCEPT: a handshake with req_last_i goes to FLUSH; a handshake that hits an error goes to ERROR.
  - FLUSH: goes to DONE once no write is pending.
  - DONE and ERROR: start_i goes to ACCEPT.
- start_i is ignored in ACCEPT and FLUSH.
- Encoding uses the package constants:
  - ADD: 0110011, f3 000, f7 0000000
  - MUL: f7 0000001
  - ADDI: 0010011, f3 000
  - LW: 0000011, f3 010
  - SW: 0100011, f3 010
  - JAL: 1101111
  - BNE: 1100011, f3 001
- Immediate field packing:
  - I-type: imm[11:0] → [31:20]
  - S-type: imm[11:5] → [31:25], imm[4:0] → [11:7]
  - B-type: imm[12|10:5] → [31|30:25], imm[4:1|11] → [11:8|7]
  - J-type: imm[20|10:1|11|19:12] → [31|30:21|20|19:12]
- Immediate legal ranges:
  - I/S: −2048..2047
  - B: −4096..4094, even
  - J: −2^20..2^20−2, even
- An out-of-range or odd B/J immediate raises err 2.
- An op_e value outside the list raises err 1.
- A handshake when accepted-word count == DEPTH raises err 3.
- An erroring request is consumed, never written, and err_o/err_code_o hold until start_i.
- Write address = BASE_ADDR + 4·count_o. count_o increments on each mem_we_o && mem_ready_i.

## Timing
- Reset values:
  - req_ready_o, mem_we_o, busy_o, done_o, err_o: 0
  - err_code_o, count_o, mem_wdata_o: 0
  - mem_addr_o: BASE_ADDR
  - FSM: IDLE
- req_ready_o = (state == ACCEPT) && (!mem_we_o || mem_ready_i). The one-entry output register gives 1 word/cycle throughput when memory is always ready.
- Latency: handshake in cycle N → mem_we_o with the encoded word in N+1. mem_we_o, address and data are held stable until mem_ready_i.
- Simultaneous drain and new handshake: the register reloads in the same cycle and mem_we_o stays high.
- busy_o = ACCEPT or FLUSH.
- done_o is high in DONE, held until start_i.
- The error check is combinational on request inputs and registered at the handshake; err_o rises in N+1.
- Reset mid-operation drops any pending write immediately (mem_we_o low asynchronously).

## Structure
- rriscv_pkg: op_e enum, opcode/funct3/funct7 constants, err_code_e, immediate range localparams.
- Sub-module imm_packer (combinational): takes op and imm, returns the placed immediate bits and a range_ok flag.
- The FSM, output register and counter live in program_encoder.

## Test plan
- start; ADDI rd1 rs1 0 imm 5, last → single write 0x00500093 @0x0, done_o high next cycle after the write.
- Stream of 3 requests, mem_ready_i constantly high:
  - ADD x3,x1,x2 → 0x002081B3
  - MUL x3,x1,x2 → 0x022081B3
  - SW x2,8(x1) → 0x0020A423
  - Writes land at 0x0, 0x4, 0x8 on consecutive cycles; count_o = 3.
- BNE x1,x2,−4 → 0xFE209EE3, then JAL x1,8 → 0x008000EF. Hold mem_ready_i low 3 cycles → address, data and we stable, req_ready_o low.
- ADDI imm 2048 → err_o=1, err_code_o=2, no write; BNE imm 3 → err 2; op_e=7 → err 1.
- DEPTH=4: 5th request → err 3, only 4 writes occur.
- Assert rst_ni mid-stream with mem_we_o pending → all outputs return to reset values; a new start_i restarts at BASE_ADDR.
